// File: rtl/vga_fb_pixel_writer.sv
// vga_fb_pixel_writer
// AXI write-side framebuffer feeder. Accepts (x,y,colour) pixel writes over
// valid/ready and issues one single-beat AXI write per pixel at
// y*H_VISIBLE + x. A frame clear fills every visible address with a latched
// colour, waits for all write responses, then pulses clear_done.
//
// Optional build macro VGA_FB_PIXEL_WRITER_CLIP_EN: pixels outside the
// visible area are still handshaked but produce no AXI write. Without it the
// address is computed as-is and may alias into other rows or wrap.
module vga_fb_pixel_writer #(
    parameter int PIXEL_BITS     = 12,
    parameter int H_VISIBLE      = 640,
    parameter int V_VISIBLE      = 480,
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int OUT_WIDTH      = 3
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(H_VISIBLE):0]    in_x,
    input  logic [$clog2(V_VISIBLE):0]    in_y,
    input  logic [PIXEL_BITS-1:0]         in_color,

    input  logic                          clear_start,
    input  logic [PIXEL_BITS-1:0]         clear_color,
    output logic                          busy,
    output logic                          clear_done,
    output logic                          err,

    output logic [AXI_ADDR_WIDTH-1:0]     axi_awaddr,
    output logic                          axi_awvalid,
    input  logic                          axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]     axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
    output logic                          axi_wvalid,
    input  logic                          axi_wready,
    input  logic [1:0]                    axi_bresp,
    input  logic                          axi_bvalid,
    output logic                          axi_bready
);

    localparam int N_PIX = H_VISIBLE * V_VISIBLE;
    localparam int CLR_W = $clog2(N_PIX);
    localparam logic [CLR_W-1:0]     CLR_LAST = CLR_W'(N_PIX - 1);
    localparam logic [OUT_WIDTH-1:0] OUT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_PIXEL,
        ST_CLEAR,
        ST_DRAIN
    } state_t;

    state_t                      r_state;
    logic [CLR_W-1:0]            r_clear_addr;
    logic [PIXEL_BITS-1:0]       r_clear_color;
    logic                        r_busy;
    logic                        r_clear_done;
    logic                        r_err;
    logic [OUT_WIDTH-1:0]        r_outstanding;
    logic [AXI_ADDR_WIDTH-1:0]   r_awaddr;
    logic                        r_awvalid;
    logic [AXI_DATA_WIDTH-1:0]   r_wdata;
    logic                        r_wvalid;

    logic                        w_slot_free;
    logic                        w_in_ready;
    logic                        w_in_bounds;
    logic                        w_pix_issue;
    logic                        w_clr_issue;
    logic                        w_issue;
    logic                        w_resp;
    logic [AXI_ADDR_WIDTH-1:0]   w_pix_addr;
    logic [AXI_ADDR_WIDTH-1:0]   w_issue_addr;
    logic [AXI_DATA_WIDTH-1:0]   w_issue_data;

    // A new beat may be loaded only when both channel registers are empty or
    // emptying this cycle, and the response tracker has room.
    assign w_slot_free = (!r_awvalid || axi_awready) && (!r_wvalid || axi_wready)
                         && (r_outstanding < OUT_MAX);

    // clear_start has priority over a pixel presented in the same cycle.
    assign w_in_ready  = (r_state == ST_PIXEL) && w_slot_free && !clear_start;

    // Row-major address; the 32-bit product wraps into the AXI address width.
    assign w_pix_addr  = AXI_ADDR_WIDTH'(32'(in_y) * 32'(H_VISIBLE) + 32'(in_x));

`ifdef VGA_FB_PIXEL_WRITER_CLIP_EN
    assign w_in_bounds = (32'(in_x) < 32'(H_VISIBLE)) && (32'(in_y) < 32'(V_VISIBLE));
`else
    assign w_in_bounds = 1'b1;
`endif

    // An out-of-bounds pixel (clip build only) is consumed without a beat.
    assign w_pix_issue = in_valid && w_in_ready && w_in_bounds;
    assign w_clr_issue = (r_state == ST_CLEAR) && w_slot_free;
    assign w_issue     = w_pix_issue || w_clr_issue;
    assign w_resp      = axi_bvalid;

    // Select address/data for the beat being loaded: clear sweep or pixel.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        w_issue_addr = w_pix_addr;
        w_issue_data = AXI_DATA_WIDTH'(in_color);
        if (r_state == ST_CLEAR) begin
            w_issue_addr = AXI_ADDR_WIDTH'(r_clear_addr);
            w_issue_data = AXI_DATA_WIDTH'(r_clear_color);
        end
    end

    // AW and W holding registers; each valid drops on its own handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
        end else if (w_issue) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
        end else begin
            if (axi_awready) r_awvalid <= 1'b0;
            if (axi_wready)  r_wvalid  <= 1'b0;
        end
    end

    // Address/data payload; only meaningful while the matching valid is high.
    always_ff @(posedge clk) begin
        // NOTE: payload registers are qualified by the valids, so they need no reset.
        if (w_issue) begin
            r_awaddr <= w_issue_addr;
            r_wdata  <= w_issue_data;
        end
    end

    // Outstanding-write count and sticky error flag from the B channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            case ({w_issue, w_resp})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
            if (axi_bvalid && (axi_bresp != 2'b00)) r_err <= 1'b1;
        end
    end

    // Mode FSM: pixel streaming, clear sweep, drain of clear responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_PIXEL;
            r_clear_addr  <= '0;
            r_clear_color <= '0;
            r_busy        <= 1'b0;
            r_clear_done  <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                ST_PIXEL: begin
                    if (clear_start) begin
                        r_state       <= ST_CLEAR;
                        r_clear_addr  <= '0;
                        r_clear_color <= clear_color;
                        r_busy        <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (w_clr_issue) begin
                        if (r_clear_addr == CLR_LAST) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_clear_addr <= r_clear_addr + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_state      <= ST_PIXEL;
                        r_busy       <= 1'b0;
                        r_clear_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_PIXEL;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign busy        = r_busy;
    assign clear_done  = r_clear_done;
    assign err         = r_err;
    assign axi_awaddr  = r_awaddr;
    assign axi_awvalid = r_awvalid;
    assign axi_wdata   = r_wdata;
    assign axi_wstrb   = '1;
    assign axi_wvalid  = r_wvalid;
    assign axi_bready  = 1'b1;

endmodule
